// File: rtl/sram_pkg.sv
// Shared types and constants for the half-word SRAM sequencing controller.
package sram_pkg;

    // Access sequencer states: idle, low half-word, high half-word, completion.
    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi,
        StDone
    } sram_state_e;

    // Byte address at which the SRAM-backed data region starts.
    localparam logic [31:0] DATA_BASE = 32'd1024;

    // Default SRAM half-word address width.
    localparam int unsigned SRAM_AW_DEFAULT = 18;

endpackage

// File: rtl/sram_read_buffer.sv
// Single-entry read buffer: valid flag, word-index tag and 32-bit data.
// Compiled only when SRAM_READ_BUFFER_EN is defined.
`ifdef SRAM_READ_BUFFER_EN
module sram_read_buffer #(
    parameter int unsigned IDX_W = 17
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_lookup_idx,
    output logic             o_hit,
    output logic [31:0]      o_data,
    input  logic             i_fill,
    input  logic             i_upd,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_data
);

    logic             r_valid;
    logic [IDX_W-1:0] r_tag;
    logic [31:0]      r_data;

    // Fill on every read completion; refresh data when a write completes to the cached word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_idx;
            r_data  <= i_data;
        end else if (i_upd && r_valid && (r_tag == i_idx)) begin
            r_data  <= i_data;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_idx);
    assign o_data = r_data;

endmodule
`endif

// File: rtl/sram_controller.sv
// Shares a 16-bit asynchronous SRAM with 32-bit MEM-stage accesses by splitting each
// word into low and high half-word phases, each held for WAIT_STATES+1 cycles.
// Optional feature macro: SRAM_READ_BUFFER_EN (single-entry read buffer, IDLE-cycle hits).
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned SRAM_AW     = SRAM_AW_DEFAULT,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam int unsigned IW      = SRAM_AW - 1;
    localparam logic [2:0]  LastCnt = 3'(WAIT_STATES);

    sram_state_e        r_state;
    logic [2:0]         r_cnt;
    logic               r_is_wr;
    logic [IW-1:0]      r_idx;
    logic [31:0]        r_wdata;
    logic [15:0]        r_lo;
    logic [31:0]        r_read_data;
    logic [SRAM_AW-1:0] r_addr;
    logic               r_we_n;
    logic               r_oe_n;

    logic [31:0]        w_offset;
    logic [IW-1:0]      w_idx;
    logic               w_req;
    logic               w_hit;
    logic               w_drive;

    // Addresses below the data base wrap through the subtraction by design.
    assign w_offset = address - DATA_BASE;
    assign w_idx    = IW'(w_offset >> 2);
    assign w_req    = wr_en | rd_en;

    // Access sequencer with registered SRAM address and strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_lo        <= '0;
            r_read_data <= '0;
            r_addr      <= '0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_req && !w_hit) begin
                        // Write wins when both requests are raised.
                        r_state <= StLo;
                        r_cnt   <= '0;
                        r_is_wr <= wr_en;
                        r_idx   <= w_idx;
                        r_wdata <= write_data;
                        r_addr  <= {w_idx, 1'b0};
                        r_we_n  <= ~wr_en;
                        r_oe_n  <= wr_en;
                    end
                end
                StLo: begin
                    if (r_cnt == LastCnt) begin
                        r_cnt   <= '0;
                        r_state <= StHi;
                        r_addr  <= {r_idx, 1'b1};
                        if (!r_is_wr) r_lo <= SRAM_DQ;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                StHi: begin
                    if (r_cnt == LastCnt) begin
                        r_cnt   <= '0;
                        r_state <= StDone;
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b0;
                        if (!r_is_wr) r_read_data <= {SRAM_DQ, r_lo};
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_addr  <= '0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef SRAM_READ_BUFFER_EN
    logic        w_buf_hit;
    logic [31:0] w_buf_data;

    sram_read_buffer #(
        .IDX_W (IW)
    ) u_read_buffer (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_lookup_idx (w_idx),
        .o_hit        (w_buf_hit),
        .o_data       (w_buf_data),
        .i_fill       ((r_state == StDone) && !r_is_wr),
        .i_upd        ((r_state == StDone) && r_is_wr),
        .i_idx        (r_idx),
        .i_data       (r_is_wr ? r_wdata : r_read_data)
    );

    // A plain read that hits completes in the IDLE cycle without touching the SRAM.
    assign w_hit     = (r_state == StIdle) && rd_en && !wr_en && w_buf_hit;
    assign read_data = w_hit ? w_buf_data : r_read_data;
`else
    assign w_hit     = 1'b0;
    assign read_data = r_read_data;
`endif

    assign ready = ((r_state == StIdle) && !w_req) || (r_state == StDone) || w_hit;

    // Drive the bus only during write phases; released as soon as the FSM leaves them.
    assign w_drive = r_is_wr && ((r_state == StLo) || (r_state == StHi));
    assign SRAM_DQ = w_drive ? ((r_state == StLo) ? r_wdata[15:0] : r_wdata[31:16]) : 16'hzzzz;

    assign SRAM_ADDR = r_addr;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural asynchronous SRAM on the bus.
module tb_sram_controller;

    localparam int unsigned AW  = 18;
    localparam int unsigned W   = 1;
    localparam int          RDY = 2 * W + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    wire  [15:0]   SRAM_DQ;
    logic [AW-1:0] SRAM_ADDR;
    logic          SRAM_WE_N;
    logic          SRAM_OE_N;
    logic          SRAM_CE_N;
    logic          SRAM_UB_N;
    logic          SRAM_LB_N;

    logic          mem_clr;
    logic [15:0]   mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_controller #(
        .SRAM_AW     (AW),
        .WAIT_STATES (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N)
    );

    // SRAM model: initial contents are addr ^ 16'hA5A5; drives the bus when OE low, WE high.
    always @(negedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 16'(i) ^ 16'hA5A5;
        end else if (!SRAM_WE_N) begin
            mem[SRAM_ADDR] <= SRAM_DQ;
        end
    end
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'hzzzz;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        logic [AW-1:0] exp_alo;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access; cycle 0 is the cycle the request is first presented.
    task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] wdata, output int rdy_cyc,
                              output logic [31:0] rdat, output int we_cnt,
                              output logic [AW-1:0] a_lo, output logic [AW-1:0] a_hi);
        @(posedge clk);
        #1;
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = wdata;
        rdy_cyc    = -1;
        we_cnt     = 0;
        a_lo       = '0;
        a_hi       = '0;
        rdat       = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!SRAM_WE_N) we_cnt++;
            if (c == 1) a_lo = SRAM_ADDR;
            if (c == int'(W) + 2) a_hi = SRAM_ADDR;
            if (ready) begin
                rdy_cyc = c;
                rdat    = read_data;
                break;
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            rc;
        int            wc;
        logic [31:0]   rd;
        logic [AW-1:0] alo;
        logic [AW-1:0] ahi;

        vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h00000000, 18'h00000};
        vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEADBEEF, 18'h00000};
        vecs[2] = '{1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 32'hDEADBEEF, 18'h00002};
        vecs[3] = '{1'b1, 1'b0, 32'd1040, 32'h01234567, 32'hDEADBEEF, 18'h00008};
        vecs[4] = '{1'b0, 1'b1, 32'd1040, 32'h0,        32'h01234567, 18'h00008};
        vecs[5] = '{1'b0, 1'b1, 32'd1036, 32'h0,        32'hA5A2A5A3, 18'h00006};
        vecs[6] = '{1'b0, 1'b1, 32'd1020, 32'h0,        32'h5A5A5A5B, 18'h3FFFE};
        vecs[7] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'hCAFEF00D, 18'h00002};

        rst        = 1'b1;
        mem_clr    = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = '0;
        write_data = '0;

        // During reset ready follows ~(rd_en|wr_en).
        @(negedge clk);
        rd_en = 1'b1;
        #1 chk("reset_ready_req", 32'(ready), 32'd0);
        rd_en = 1'b0;
        #1 chk("reset_ready_noreq", 32'(ready), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_clr = 1'b0;

        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("idle_oe_n", 32'(SRAM_OE_N), 32'd0);
        chk("idle_ce_n", 32'(SRAM_CE_N), 32'd0);
        chk("idle_rdata", read_data, 32'd0);
        chk("idle_addr", 32'(SRAM_ADDR), 32'd0);
        chk("idle_dq_released", 32'(SRAM_DQ), 32'h0000A5A5);

        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, rc, rd, wc, alo, ahi);
            chk($sformatf("v%0d_ready_cycle", i), 32'(rc), 32'(RDY));
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_we_cycles", i), 32'(wc), vecs[i].wr ? 32'(2 * (W + 1)) : 32'd0);
            chk($sformatf("v%0d_addr_lo", i), 32'(alo), 32'(vecs[i].exp_alo));
            chk($sformatf("v%0d_addr_hi", i), 32'(ahi), 32'(vecs[i].exp_alo + 18'd1));
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_mem_lo", i), 32'(mem[vecs[i].exp_alo]),
                    32'(vecs[i].wdata[15:0]));
                chk($sformatf("v%0d_mem_hi", i), 32'(mem[vecs[i].exp_alo + 18'd1]),
                    32'(vecs[i].wdata[31:16]));
            end
            @(negedge clk);
            chk($sformatf("v%0d_after_addr", i), 32'(SRAM_ADDR), 32'd0);
            chk($sformatf("v%0d_after_ready", i), 32'(ready), 32'd1);
        end

        // Reset in cycle 2 of a write to 1032: WE_N releases at once, bus released.
        @(posedge clk);
        #1;
        wr_en      = 1'b1;
        address    = 32'd1032;
        write_data = 32'h55AA33CC;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_we_before", 32'(SRAM_WE_N), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_we_after", 32'(SRAM_WE_N), 32'd1);
        chk("midrst_dq", 32'(SRAM_DQ), 32'h0000BEEF);
        chk("midrst_ready_req", 32'(ready), 32'd0);
        wr_en = 1'b0;
        #1 chk("midrst_ready_noreq", 32'(ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        // The low phase landed before reset; the high half-word keeps its initial pattern.
        run_access(1'b0, 1'b1, 32'd1032, 32'h0, rc, rd, wc, alo, ahi);
        chk("midrst_read_cycle", 32'(rc), 32'(RDY));
        chk("midrst_read_data", rd, 32'hA5A033CC);

`ifdef SRAM_READ_BUFFER_EN
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, rc, rd, wc, alo, ahi);
        chk("buf_miss_cycle", 32'(rc), 32'(RDY));
        chk("buf_miss_data", rd, 32'hDEADBEEF);
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, rc, rd, wc, alo, ahi);
        chk("buf_hit_cycle", 32'(rc), 32'd0);
        chk("buf_hit_data", rd, 32'hDEADBEEF);
        run_access(1'b1, 1'b0, 32'd1024, 32'h12345678, rc, rd, wc, alo, ahi);
        chk("buf_wr_cycle", 32'(rc), 32'(RDY));
        chk("buf_wr_mem", 32'(mem[0]), 32'h00005678);
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, rc, rd, wc, alo, ahi);
        chk("buf_upd_cycle", 32'(rc), 32'd0);
        chk("buf_upd_data", rd, 32'h12345678);
`else
        // Without the buffer a repeated read runs the full sequence again.
        for (int k = 0; k < 2; k++) begin
            run_access(1'b0, 1'b1, 32'd1024, 32'h0, rc, rd, wc, alo, ahi);
            chk($sformatf("reread%0d_cycle", k), 32'(rc), 32'(RDY));
            chk($sformatf("reread%0d_data", k), rd, 32'hDEADBEEF);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
